// File: rtl/cordic_pkg.sv
// cordic_pkg: mode type and elaboration-time constants (angle scale, atan table, gain) for cordic_engine.
package cordic_pkg;
  typedef enum logic {VECTOR = 1'b0, ROTATE = 1'b1} mode_t;
  function automatic longint cordic_pi(input int width, input bit half);
    return longint'(1) << (width - (half ? 2 : 1));
  endfunction
  // atan(2^-n) by its Taylor series; n = 0 is the exact pi/4 since the series converges too slowly there
  function automatic int cordic_atan(input int n, input int width);
    real t, p, s;
    t = 1.0;
    for (int i = 0; i < n; i++) t = t / 2.0;
    s = 0.0;
    p = t;
    if (n == 0) s = 0.7853981633974483;
    else for (int k = 0; k < 24; k++) begin
      s = s + ((k % 2 != 0) ? -p : p) / real'(2 * k + 1);
      p = p * t * t;
    end
    return $rtoi(s * real'(cordic_pi(width, 1'b0)) / 3.141592653589793 + 0.5);
  endfunction
  function automatic int cordic_gain(input int width);
    return $rtoi(0.607253 * real'(cordic_pi(width, 1'b0)) + 0.5);
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one micro-rotation by atan(2^-SHIFT) with its valid/mode/tag registers.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               TAG_WIDTH = 1,
  parameter int               SHIFT     = 0,
  parameter logic [WIDTH-1:0] ATAN      = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic                   i_mode,
  input  logic signed [WIDTH+1:0] i_x,
  input  logic signed [WIDTH+1:0] i_y,
  input  logic signed [WIDTH-1:0] i_z,
  input  logic [TAG_WIDTH-1:0]   i_tag,
  output logic                   o_valid,
  output logic                   o_mode,
  output logic signed [WIDTH+1:0] o_x,
  output logic signed [WIDTH+1:0] o_y,
  output logic signed [WIDTH-1:0] o_z,
  output logic [TAG_WIDTH-1:0]   o_tag
);
  logic                    w_ccw;
  logic signed [WIDTH+1:0] w_xs, w_ys;
  // rotation drives z toward 0, vectoring drives y toward 0
  assign w_ccw = (i_mode == ROTATE) ? !i_z[WIDTH-1] : i_y[WIDTH+1];
  assign w_xs  = i_x >>> SHIFT;
  assign w_ys  = i_y >>> SHIFT;
  always_ff @(posedge clk)
    if (reset) begin
      o_valid <= 1'b0;
      o_mode  <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
      o_tag   <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_mode  <= i_mode;
      o_x     <= w_ccw ? i_x - w_ys : i_x + w_ys;
      o_y     <= w_ccw ? i_y + w_xs : i_y - w_xs;
      o_z     <= w_ccw ? i_z - ATAN : i_z + ATAN;
      o_tag   <= i_tag;
    end
endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: fully pipelined CORDIC, vectoring or rotation per sample, valid/ready streaming.
// Define CORDIC_GAIN_COMP_EN to add a registered gain-compensation stage (gain 0.5, latency +1).
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 14,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_mode,
  input  logic [2*WIDTH-1:0]   s_data,
  input  logic [WIDTH-1:0]     s_angle,
  input  logic [TAG_WIDTH-1:0] s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_data,
  output logic [TAG_WIDTH-1:0] m_tag
);
  localparam int XW = WIDTH + 2;
  localparam logic signed [WIDTH-1:0] PI_2 = WIDTH'(cordic_pi(WIDTH, 1'b1));
  logic                    w_en;
  logic signed [XW-1:0]    w_sx, w_sy, w_px, w_py;
  logic signed [WIDTH-1:0] w_sa, w_pz;
  logic                    r_valid, r_mode;
  logic signed [XW-1:0]    r_x, r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    w_valid [STAGES+1];
  logic                    w_mode  [STAGES+1];
  logic signed [XW-1:0]    w_x     [STAGES+1];
  logic signed [XW-1:0]    w_y     [STAGES+1];
  logic signed [WIDTH-1:0] w_z     [STAGES+1];
  logic [TAG_WIDTH-1:0]    w_tag   [STAGES+1];
  logic [2*WIDTH-1:0]      w_out;

  assign w_en    = !m_valid || m_ready;
  assign s_ready = w_en;
  assign w_sx    = {{2{s_data[WIDTH-1]}}, s_data[WIDTH-1:0]};
  assign w_sy    = {{2{s_data[2*WIDTH-1]}}, s_data[2*WIDTH-1:WIDTH]};
  assign w_sa    = s_angle;

  // quarter-turn pre-rotation brings every sample into the +-pi/2 convergence range
  always_comb begin
    w_px = w_sx;
    w_py = w_sy;
    w_pz = '0;
    if (s_mode == ROTATE) begin
      w_px = (w_sa > PI_2) ? -w_sy : (w_sa < -PI_2) ? w_sy : w_sx;
      w_py = (w_sa > PI_2) ? w_sx : (w_sa < -PI_2) ? -w_sx : w_sy;
      w_pz = (w_sa > PI_2) ? w_sa - PI_2 : (w_sa < -PI_2) ? w_sa + PI_2 : w_sa;
    end else if (w_sx[XW-1]) begin
      w_px = w_sy[XW-1] ? -w_sy : w_sy;
      w_py = w_sy[XW-1] ? w_sx : -w_sx;
      w_pz = w_sy[XW-1] ? -PI_2 : PI_2;
    end
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_tag   <= '0;
    end else if (w_en) begin
      r_valid <= s_valid;
      r_mode  <= s_mode;
      r_x     <= w_px;
      r_y     <= w_py;
      r_z     <= w_pz;
      r_tag   <= s_tag;
    end

  assign w_valid[0] = r_valid;
  assign w_mode[0]  = r_mode;
  assign w_x[0]     = r_x;
  assign w_y[0]     = r_y;
  assign w_z[0]     = r_z;
  assign w_tag[0]   = r_tag;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .SHIFT(i), .ATAN(WIDTH'(cordic_atan(i, WIDTH)))
    ) u_stage (
      .clk(clk), .reset(reset), .i_en(w_en),
      .i_valid(w_valid[i]), .i_mode(w_mode[i]), .i_x(w_x[i]), .i_y(w_y[i]), .i_z(w_z[i]), .i_tag(w_tag[i]),
      .o_valid(w_valid[i+1]), .o_mode(w_mode[i+1]), .o_x(w_x[i+1]), .o_y(w_y[i+1]), .o_z(w_z[i+1]),
      .o_tag(w_tag[i+1])
    );
  end

  // drop the LSB and clamp to the signed WIDTH range instead of wrapping
  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] h;
    h = v >>> 1;
    return (h[XW-1:WIDTH-1] == {(XW-WIDTH+1){h[WIDTH-1]}}) ? h[WIDTH-1:0]
                                                          : {h[XW-1], {(WIDTH-1){~h[XW-1]}}};
  endfunction

  assign w_out = (w_mode[STAGES] == ROTATE) ? {sat(w_y[STAGES]), sat(w_x[STAGES])}
                                            : {w_z[STAGES], sat(w_x[STAGES])};

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH-1:0]   GC  = WIDTH'(cordic_gain(WIDTH));
  localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(1) << (WIDTH-2);
  logic                 r_cvalid;
  logic [2*WIDTH-1:0]   r_cdata;
  logic [TAG_WIDTH-1:0] r_ctag;
  function automatic logic [WIDTH-1:0] comp(input logic signed [WIDTH-1:0] v);
    return WIDTH'(((2*WIDTH)'(v) * (2*WIDTH)'(GC) + RND) >>> (WIDTH-1));
  endfunction
  always_ff @(posedge clk)
    if (reset) begin
      r_cvalid <= 1'b0;
      r_cdata  <= '0;
      r_ctag   <= '0;
    end else if (w_en) begin
      r_cvalid <= w_valid[STAGES];
      r_cdata  <= {(w_mode[STAGES] == ROTATE) ? comp(w_out[2*WIDTH-1:WIDTH]) : w_out[2*WIDTH-1:WIDTH],
                   comp(w_out[WIDTH-1:0])};
      r_ctag   <= w_tag[STAGES];
    end
  assign m_valid = r_cvalid;
  assign m_data  = r_cdata;
  assign m_tag   = r_ctag;
`else
  assign m_valid = w_valid[STAGES];
  assign m_data  = w_out;
  assign m_tag   = w_tag[STAGES];
`endif
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed and streaming checks of cordic_engine (WIDTH=16, STAGES=14).
module tb_cordic_engine;
  localparam int  STAGES = 14;
  localparam real PI     = 3.141592653589793;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT    = STAGES + 2;
  localparam real G      = 0.5;
  localparam int  E_MAG0 = 8192;
  localparam int  E_MAG45 = 11585;
  localparam int  E_ROT  = 5793;
  localparam int  E_SAT  = 19897;
`else
  localparam int  LAT    = STAGES + 1;
  localparam real G      = 0.82338013;
  localparam int  E_MAG0 = 13490;
  localparam int  E_MAG45 = 19078;
  localparam int  E_ROT  = 9539;
  localparam int  E_SAT  = 32767;
`endif
  localparam real TOL = 10.0;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, s_mode, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic [15:0] s_angle;
  logic [0:0]  s_tag, m_tag;
  int errors = 0;
  int checks = 0;

  typedef struct { logic rot; real e0; real e1; logic tag; } exp_t;
  exp_t q[$];

  cordic_engine #(.WIDTH(16), .STAGES(STAGES), .TAG_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
    .s_data(s_data), .s_angle(s_angle), .s_tag(s_tag), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_tag(m_tag)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic run_one(input logic mode, input int x, input int y, input int a,
                         output int lo, output int hi, output int lat);
    shortint l, h;
    @(posedge clk); #1;
    s_mode = mode; s_data = {16'(y), 16'(x)}; s_angle = 16'(a); s_tag = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1 s_valid = 1'b0;
      @(negedge clk);
    end while (!m_valid && lat < 40);
    l = m_data[15:0]; h = m_data[31:16];
    lo = l; hi = h;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_mode = 1'b0; s_data = '0; s_angle = '0; s_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    checks++; if (m_tag !== 1'b0) begin errors++; $display("FAIL reset_m_tag got=%b want=0", m_tag); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_vectoring();
    int lo, hi, lat;
    run_one(1'b0, 16384, 0, 0, lo, hi, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL vec_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (iabs(lo - E_MAG0) > 2) begin errors++; $display("FAIL vec_x_mag got=%0d want=%0d+-2", lo, E_MAG0); end
    checks++; if (iabs(hi) > 2) begin errors++; $display("FAIL vec_x_angle got=%0d want=0+-2", hi); end
    run_one(1'b0, 0, 16384, 0, lo, hi, lat);
    checks++; if (iabs(hi - 16384) > 2) begin errors++; $display("FAIL vec_y_angle got=%0d want=16384+-2", hi); end
    run_one(1'b0, -16384, 0, 0, lo, hi, lat);
    checks++; if (iabs(hi) < 32765) begin errors++; $display("FAIL vec_negx_angle got=%0d want=+-32767", hi); end
    run_one(1'b0, -16384, -16384, 0, lo, hi, lat);
    checks++; if (iabs(hi + 24576) > 2) begin errors++; $display("FAIL vec_q3_angle got=%0d want=-24576+-2", hi); end
    checks++; if (iabs(lo - E_MAG45) > 3) begin errors++; $display("FAIL vec_q3_mag got=%0d want=%0d+-3", lo, E_MAG45); end
    run_one(1'b0, -32768, -32768, 0, lo, hi, lat);
    checks++; if (lo !== E_SAT) begin errors++; $display("FAIL vec_corner_sat got=%0d want=%0d", lo, E_SAT); end
    checks++; if (iabs(hi + 24576) > 3) begin errors++; $display("FAIL vec_corner_angle got=%0d want=-24576+-3", hi); end
  endtask

  task automatic test_rotation();
    int lo, hi, lat;
    run_one(1'b1, 16384, 0, 8192, lo, hi, lat);
    checks++; if (iabs(lo - E_ROT) > 3) begin errors++; $display("FAIL rot45_x got=%0d want=%0d+-3", lo, E_ROT); end
    checks++; if (iabs(hi - E_ROT) > 3) begin errors++; $display("FAIL rot45_y got=%0d want=%0d+-3", hi, E_ROT); end
    run_one(1'b1, 16384, 0, -32768, lo, hi, lat);
    checks++; if (iabs(lo + E_MAG0) > 2) begin errors++; $display("FAIL rot180_x got=%0d want=%0d+-2", lo, -E_MAG0); end
    checks++; if (iabs(hi) > 3) begin errors++; $display("FAIL rot180_y got=%0d want=0+-3", hi); end
  endtask

  task automatic test_back_to_back();
    exp_t   e, pend;
    int     sent = 0, got = 0, cyc = 0, x, y, a;
    logic   acc, stl = 1'b0;
    logic [31:0] hd;
    logic [0:0]  ht;
    shortint lo, hi;
    real    xr, yr, ar, d0, d1;
    s_valid = 1'b0; m_ready = 1'b1;
    while (got < 100 && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (stl) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hd || m_tag !== ht) begin
          errors++; $display("FAIL b2b_stall got=%b/%h/%b want=1/%h/%b", m_valid, m_data, m_tag, hd, ht);
        end
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra got=%h want=none", m_data);
        end else begin
          e = q.pop_front(); got++;
          lo = m_data[15:0]; hi = m_data[31:16];
          d0 = real'(lo) - e.e0;
          d1 = real'(hi) - e.e1;
          if (!e.rot) begin
            while (d1 > 32768.0) d1 = d1 - 65536.0;
            while (d1 < -32768.0) d1 = d1 + 65536.0;
          end
          checks++;
          if (d0 > TOL || d0 < -TOL || d1 > TOL || d1 < -TOL) begin
            errors++; $display("FAIL b2b_data #%0d got=%0d,%0d want=%0f,%0f", got, lo, hi, e.e0, e.e1);
          end
          checks++; if (m_tag !== e.tag) begin errors++; $display("FAIL b2b_tag #%0d got=%b want=%b", got, m_tag, e.tag); end
        end
      end
      stl = m_valid && !m_ready; hd = m_data; ht = m_tag;
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) begin q.push_back(pend); sent++; s_valid = 1'b0; end
      if (!s_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        do begin
          x = int'($urandom_range(0, 32000)) - 16000;
          y = int'($urandom_range(0, 32000)) - 16000;
        end while (x * x + y * y < 64000000);
        a = int'($urandom_range(0, 65535)) - 32768;
        xr = real'(x); yr = real'(y); ar = real'(a) * PI / 32768.0;
        pend.rot = 1'($urandom_range(0, 1));
        pend.tag = 1'($urandom_range(0, 1));
        pend.e0 = pend.rot ? G * (xr * $cos(ar) - yr * $sin(ar)) : G * $sqrt(xr * xr + yr * yr);
        pend.e1 = pend.rot ? G * (xr * $sin(ar) + yr * $cos(ar)) : $atan2(yr, xr) * 32768.0 / PI;
        s_mode = pend.rot; s_data = {16'(y), 16'(x)}; s_angle = 16'(a); s_tag = pend.tag; s_valid = 1'b1;
      end
      m_ready = $urandom_range(0, 2) != 0;
    end
    checks++;
    if (got !== 100 || q.size() !== 0) begin
      errors++; $display("FAIL b2b_count got=%0d left=%0d want=100 left=0", got, q.size());
    end
  endtask

  task automatic test_reset_flush();
    int   lo, hi, lat;
    logic stale = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_mode = i[0]; s_data = {16'(i * 100), 16'd5000}; s_angle = 16'(i * 1000); s_tag = 1'b1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got=%b want=0", m_valid); end
    reset = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (m_valid) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL flush_stale got=%b want=0", stale); end
    run_one(1'b0, 16384, 0, 0, lo, hi, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL flush_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (iabs(lo - E_MAG0) > 2) begin errors++; $display("FAIL flush_mag got=%0d want=%0d+-2", lo, E_MAG0); end
    checks++; if (m_tag !== 1'b1) begin errors++; $display("FAIL flush_tag got=%b want=1", m_tag); end
  endtask

  initial begin
    test_reset();
    test_vectoring();
    test_rotation();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
